fetch_request_ctrl: RTL and testbench

- Initiator end of the fetch sub-unit interface. Drives new_request and stage1_addr into an instruction memory sub-unit, such as the instruction BRAM responder.
- Collects in-order responses into a small instruction queue and presents {pc, instr} to decode with a valid/ready handshake.
- Handles branch redirects by discarding in-flight responses.

---
 rtl/fetch_request_ctrl_pkg.sv | 9 +
 rtl/fetch_instr_fifo.sv | 49 ++++
 rtl/fetch_request_ctrl.sv | 121 ++++++++++++
 tb/tb_fetch_request_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_request_ctrl_pkg.sv
// rtl/fetch_request_ctrl_pkg.sv - shared types and constants for the fetch request controller
package fetch_request_ctrl_pkg;
  localparam int          INSTR_W           = 32;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_instr_fifo.sv
// rtl/fetch_instr_fifo.sv - instruction queue with push/pop/flush and occupancy count
module fetch_instr_fifo
  import fetch_request_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic [AW:0]  o_count
);
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  fetch_entry_t r_mem [DEPTH];
  logic         w_empty;
  logic         w_full;
  logic         w_do_push;
  logic         w_do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push & !w_full & !i_flush;
  assign w_do_pop  = i_pop & !w_empty & !i_flush;
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end
endmodule

// File: rtl/fetch_request_ctrl.sv
// rtl/fetch_request_ctrl.sv - fetch initiator: credit-limited issue, in-order response queue, redirect flush
// Optional FETCH_PERF_COUNTERS_EN adds stall_cycles and discarded_words outputs.
module fetch_request_ctrl
  import fetch_request_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VEC       = DEFAULT_RESET_VEC,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sub_ready,
  output logic        new_request,
  output logic [31:0] stage1_addr,
  input  logic        data_valid,
  input  logic [31:0] data_in,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] discarded_words
`endif
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_head_pc;
  logic [OW-1:0] r_outstanding;
  logic [OW-1:0] r_discard;
  logic [CW-1:0] w_count;
  fetch_entry_t w_head;
  fetch_entry_t w_push_entry;
  logic         w_resp;
  logic         w_drop;
  logic         w_push;
  logic         w_pop;
  logic         w_issue;
  logic         w_credit_ok;
  logic         w_out_ok;
  logic         w_unused_pc_bits;

  // Each outstanding request holds a queue slot, so the queue can never overflow.
  assign w_credit_ok  = (int'(w_count) + int'(r_outstanding)) < FIFO_DEPTH;
  assign w_out_ok     = int'(r_outstanding) < MAX_OUTSTANDING;
  assign w_issue      = !rst & sub_ready & !redirect & w_out_ok & w_credit_ok;
  assign w_resp       = data_valid & (r_outstanding != '0);
  assign w_drop       = w_resp & (redirect | (r_discard != '0));
  assign w_push       = w_resp & !w_drop;
  assign w_pop        = instr_valid & instr_ready & !redirect;
  assign w_push_entry.instr = data_in;
  assign w_unused_pc_bits   = ^redirect_pc[1:0];

  assign new_request = w_issue;
  assign stage1_addr = r_fetch_pc;
  assign instr_valid = (w_count != '0);
  assign instr       = w_head.instr;
  assign instr_pc    = r_head_pc;

  fetch_instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_data(w_push_entry),
    .i_pop      (w_pop),
    .i_flush    (redirect),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_VEC;
      r_head_pc     <= RESET_VEC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      if (w_issue && !w_resp)      r_outstanding <= r_outstanding + OW'(1);
      else if (!w_issue && w_resp) r_outstanding <= r_outstanding - OW'(1);

      // Everything still in flight at a redirect is stale; a word landing this cycle is dropped now.
      if (redirect)                    r_discard <= r_outstanding - (w_resp ? OW'(1) : OW'(0));
      else if (w_resp && r_discard != '0) r_discard <= r_discard - OW'(1);

      if (redirect) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
        r_head_pc  <= {redirect_pc[31:2], 2'b00};
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_pop)   r_head_pc  <= r_head_pc + 32'd4;
      end
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_discarded_words;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles    <= '0;
      r_discarded_words <= '0;
    end else begin
      if (sub_ready && !redirect && !w_issue && r_stall_cycles != '1)
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_drop && r_discarded_words != '1)
        r_discarded_words <= r_discarded_words + 16'd1;
    end
  end

  assign stall_cycles    = r_stall_cycles;
  assign discarded_words = r_discarded_words;
`endif

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst) !(data_valid && r_outstanding == '0));
endmodule

// File: tb/tb_fetch_request_ctrl.sv
// tb/tb_fetch_request_ctrl.sv - self-checking bench: directed vectors, corner sequences, random traffic vs reference model
module tb_fetch_request_ctrl;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        sub_ready, new_request, data_valid, redirect, instr_valid, instr_ready;
  logic [31:0] stage1_addr, data_in, redirect_pc, instr, instr_pc;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] stall_cycles;
  logic [15:0] discarded_words;
`endif

  fetch_request_ctrl #(.RESET_VEC(RV), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst), .sub_ready(sub_ready), .new_request(new_request),
    .stage1_addr(stage1_addr), .data_valid(data_valid), .data_in(data_in),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_PERF_COUNTERS_EN
    , .stall_cycles(stall_cycles), .discarded_words(discarded_words)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  typedef struct {
    logic sr, dv, ir;
    logic nr; logic [31:0] addr; logic iv; logic [31:0] pc;
  } vec_t;

  pend_t       pend[$];
  ent_t        mq[$];
  logic [31:0] issued[$];
  logic [31:0] popped[$];
  logic [31:0] m_fetch_pc;
  int          m_epoch, stale_cnt, n_tests, n_fail;
  logic        c_dv, c_ir, c_rd, e_nr, e_iv;
  logic [31:0] c_rpc;
  vec_t        tbl[10];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sr, input logic dvreq, input logic ir, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    c_dv  = dvreq && (pend.size() != 0);
    c_ir  = ir;
    c_rd  = rd;
    c_rpc = rpc;
    sub_ready   = sr;
    data_valid  = c_dv;
    data_in     = c_dv ? mem_word(pend[0].addr) : $urandom;
    instr_ready = ir;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    e_nr = sr && !rd && (pend.size() < 2) && (mq.size() + pend.size() < 4);
    e_iv = (mq.size() != 0);
    chk("new_request", new_request, e_nr);
    chk("stage1_addr", stage1_addr, m_fetch_pc);
    chk("instr_valid", instr_valid, e_iv);
    if (e_iv) begin
      chk("instr_pc", instr_pc, mq[0].pc);
      chk("instr", instr, mq[0].ins);
    end
  endtask

  task automatic step();
    pend_t p;
    @(posedge clk);
    if (e_iv && c_ir && !c_rd) begin
      popped.push_back(mq[0].pc);
      mq.delete(0);
    end
    if (c_dv) begin
      p = pend.pop_front();
      if (p.epoch == m_epoch && !c_rd) mq.push_back('{p.addr, mem_word(p.addr)});
      else stale_cnt++;
    end
    if (e_nr) begin
      issued.push_back(m_fetch_pc);
      pend.push_back('{m_fetch_pc, m_epoch});
      m_fetch_pc += 32'd4;
    end
    if (c_rd) begin
      mq.delete();
      m_epoch++;
      m_fetch_pc = {c_rpc[31:2], 2'b00};
    end
  endtask

  task automatic model_reset();
    pend.delete();
    mq.delete();
    m_fetch_pc = RV;
    m_epoch++;
  endtask

  initial begin
    int s0, p0, i0, n_iv;
    n_tests = 0; n_fail = 0; stale_cnt = 0; m_epoch = 0; m_fetch_pc = RV;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h4};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h4};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h14, 1'b1, 32'h4};

    rst = 1'b1; sub_ready = 1'b1; data_valid = 1'b0; data_in = '0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_new_request", new_request, 1'b0);
    chk("reset_instr_valid", instr_valid, 1'b0);
    chk("reset_stage1_addr", stage1_addr, RV);
    chk("reset_instr_pc", instr_pc, RV);
    sub_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Credit limit with decode stalled, one-cycle responder.
    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].sr, tbl[k].dv, tbl[k].ir, 1'b0, 32'h0);
      chk($sformatf("tbl%0d_new_request", k), new_request, tbl[k].nr);
      chk($sformatf("tbl%0d_stage1_addr", k), stage1_addr, tbl[k].addr);
      chk($sformatf("tbl%0d_instr_valid", k), instr_valid, tbl[k].iv);
      if (tbl[k].iv) chk($sformatf("tbl%0d_instr_pc", k), instr_pc, tbl[k].pc);
      step();
    end
    chk("tbl_issue_count", issued.size(), 5);

    // Latency and sustained throughput after a redirect.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
    step();
    n_iv = 0;
    p0 = popped.size();
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (k == 0) chk("lat_first_issue", new_request, 1'b1);
      if (k == 1) chk("lat_not_yet_valid", instr_valid, 1'b0);
      if (k == 2) chk("lat_first_pc", instr_pc, 32'h40);
      if (k >= 2 && instr_valid) n_iv++;
      step();
    end
    chk("throughput_valid_cycles", n_iv, 10);
    chk("throughput_pops", popped.size() - p0, 10);

    // Redirect with two requests in flight.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0); step();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0); step();
    chk("two_outstanding", pend.size(), 2);
    s0 = stale_cnt;
    p0 = popped.size();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0101); step();
    for (int k = 0; k < 8; k++) begin drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0); step(); end
    chk("redir2_stale_dropped", stale_cnt - s0, 2);
    chk("redir2_first_pc", popped[p0], 32'h100);

    // Redirect coincident with a response, one outstanding.
    chk("one_outstanding", pend.size(), 1);
    s0 = stale_cnt;
    p0 = popped.size();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200); step();
    chk("redir1_drop_now", stale_cnt - s0, 1);
    for (int k = 0; k < 6; k++) begin drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0); step(); end
    chk("redir1_no_more_stale", stale_cnt - s0, 1);
    chk("redir1_first_pc", popped[p0], 32'h200);

    // Address wrap at the top of the space.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8); step();
    i0 = issued.size();
    p0 = popped.size();
    for (int k = 0; k < 6; k++) begin drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0); step(); end
    chk("wrap_issue0", issued[i0],     32'hFFFF_FFF8);
    chk("wrap_issue1", issued[i0 + 1], 32'hFFFF_FFFC);
    chk("wrap_issue2", issued[i0 + 2], 32'h0000_0000);
    chk("wrap_pop0",   popped[p0],     32'hFFFF_FFF8);
    chk("wrap_pop1",   popped[p0 + 1], 32'hFFFF_FFFC);
    chk("wrap_pop2",   popped[p0 + 2], 32'h0000_0000);

    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 3, $urandom);
      step();
    end

    // Asynchronous reset with two outstanding and a non-empty queue.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0300); step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0); step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("pre_rst_outstanding", pend.size(), 2);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_new_request", new_request, 1'b0);
    chk("rst_async_instr_valid", instr_valid, 1'b0);
    chk("rst_async_instr_pc", instr_pc, RV);
    chk("rst_async_stage1_addr", stage1_addr, RV);
    sub_ready = 1'b0; data_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("post_rst_first_addr", stage1_addr, RV);
    chk("post_rst_issue", new_request, 1'b1);
    step();
    for (int k = 0; k < 3; k++) begin drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); step(); end
    for (int k = 0; k < 8; k++) begin drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0); step(); end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
